// File: rtl/regfile_writeback.sv
// Register file write-port driver: merges ALU results with load responses,
// extracts/extends load data and flags bad or timed-out loads.
module regfile_writeback #(
  parameter int XLEN       = 32,
  parameter int RA_W       = 5,
  parameter int LD_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [RA_W-1:0] alu_rd,
  input  logic [XLEN-1:0] alu_result,
  input  logic            ld_req_valid,
  output logic            ld_req_ready,
  input  logic [RA_W-1:0] ld_rd,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_addr_lo,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  output logic            rf_we,
  output logic [RA_W-1:0] rf_rd,
  output logic [XLEN-1:0] rf_wdata,
  output logic            ld_busy,
  output logic [RA_W-1:0] ld_busy_rd,
  output logic            ld_err
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RSP,
    WRITE
  } state_t;

  localparam logic [7:0] LP_TO_LAST = 8'(LD_TIMEOUT - 1);

  state_t          r_state;
  logic [7:0]      r_cnt;
  logic [RA_W-1:0] r_rd;
  logic [2:0]      r_f3;
  logic [1:0]      r_lo;
  logic [XLEN-1:0] r_hold;
  logic            r_err;
  logic            r_we;
  logic [RA_W-1:0] r_wrd;
  logic [XLEN-1:0] r_wdata;

  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_ext;
  logic            w_f3_ok;
  logic            w_mis;
  logic            w_req_ok;

  always_comb begin
    w_byte = mem_rsp_data[{r_lo, 3'b000} +: 8];
    w_half = mem_rsp_data[{r_lo[1], 4'b0000} +: 16];
    case (r_f3)
      3'd0:    w_ext = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'd1:    w_ext = {{(XLEN-16){w_half[15]}}, w_half};
      3'd4:    w_ext = {{(XLEN-8){1'b0}}, w_byte};
      3'd5:    w_ext = {{(XLEN-16){1'b0}}, w_half};
      default: w_ext = mem_rsp_data;
    endcase
  end

  always_comb begin
    w_f3_ok  = (ld_funct3 != 3'd3) && (ld_funct3 != 3'd6)
            && (ld_funct3 != 3'd7);
    w_mis    = ((ld_funct3[1:0] == 2'd1) && ld_addr_lo[0])
            || ((ld_funct3 == 3'd2) && (ld_addr_lo != 2'd0));
    w_req_ok = w_f3_ok && !w_mis;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rd    <= '0;
      r_f3    <= '0;
      r_lo    <= '0;
      r_hold  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (ld_req_valid) begin
            if (w_req_ok) begin
              r_rd    <= ld_rd;
              r_f3    <= ld_funct3;
              r_lo    <= ld_addr_lo;
              r_state <= WAIT_RSP;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        WAIT_RSP: begin
          if (mem_rsp_valid) begin
            r_hold  <= w_ext;
            r_state <= WRITE;
          end else if (r_cnt == LP_TO_LAST) begin
            r_err   <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        WRITE:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // The WRITE state owns the port; ALU is stalled via alu_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_wrd   <= '0;
      r_wdata <= '0;
    end else if (r_state == WRITE) begin
      r_we    <= (r_rd != '0);
      r_wrd   <= r_rd;
      r_wdata <= r_hold;
    end else if (alu_valid) begin
      r_we    <= (alu_rd != '0);
      r_wrd   <= alu_rd;
      r_wdata <= alu_result;
    end else begin
      r_we <= 1'b0;
    end
  end

  assign alu_ready    = (r_state != WRITE);
  assign ld_req_ready = (r_state == IDLE);
  assign ld_busy      = (r_state != IDLE);
  assign ld_busy_rd   = ld_busy ? r_rd : '0;
  assign ld_err       = r_err;
  assign rf_we        = r_we;
  assign rf_rd        = r_wrd;
  assign rf_wdata     = r_wdata;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed self-checking bench for regfile_writeback.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_result;
  logic        ld_req_valid;
  logic        ld_req_ready;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        ld_busy;
  logic [4:0]  ld_busy_rd;
  logic        ld_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regfile_writeback dut (
    .clk          (clk),
    .rst          (rst),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_rd       (alu_rd),
    .alu_result   (alu_result),
    .ld_req_valid (ld_req_valid),
    .ld_req_ready (ld_req_ready),
    .ld_rd        (ld_rd),
    .ld_funct3    (ld_funct3),
    .ld_addr_lo   (ld_addr_lo),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data (mem_rsp_data),
    .rf_we        (rf_we),
    .rf_rd        (rf_rd),
    .rf_wdata     (rf_wdata),
    .ld_busy      (ld_busy),
    .ld_busy_rd   (ld_busy_rd),
    .ld_err       (ld_err)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] exp;
    logic        we;
  } ldvec_t;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    alu_valid = 0; alu_rd = 0; alu_result = 0;
    ld_req_valid = 0; ld_rd = 0; ld_funct3 = 0; ld_addr_lo = 0;
    mem_rsp_valid = 0; mem_rsp_data = 0;
    repeat (3) cyc();
    n_tests++;
    if ({rf_we, ld_busy, ld_err, ld_busy_rd} !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_outs: we/busy/err/brd=%b%b%b%h req 0",
               rf_we, ld_busy, ld_err, ld_busy_rd);
    end
    n_tests++;
    if ({ld_req_ready, alu_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_ready: got %b%b req 11",
               ld_req_ready, alu_ready);
    end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_alu();
    alu_valid = 1; alu_rd = 5; alu_result = 32'hDEADBEEF;
    cyc();
    alu_valid = 0;
    n_tests++;
    if ({rf_we, rf_rd, rf_wdata} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL alu_write: got we=%b rd=%0d d=%h req 1 5 deadbeef",
               rf_we, rf_rd, rf_wdata);
    end
    cyc();
    n_tests++;
    if (rf_we !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_idle: got we=%b req 0", rf_we);
    end
    alu_valid = 1; alu_rd = 0; alu_result = 32'h1234;
    cyc();
    alu_valid = 0;
    n_tests++;
    if (rf_we !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_x0: got we=%b req 0", rf_we);
    end
  endtask

  task automatic test_load_extract();
    ldvec_t v[9];
    v[0] = '{3'd0, 2'd3, 5'd9,  32'h80112233, 32'hFFFFFF80, 1'b1};
    v[1] = '{3'd4, 2'd3, 5'd9,  32'h80112233, 32'h00000080, 1'b1};
    v[2] = '{3'd1, 2'd2, 5'd10, 32'h80112233, 32'hFFFF8011, 1'b1};
    v[3] = '{3'd5, 2'd2, 5'd10, 32'h80112233, 32'h00008011, 1'b1};
    v[4] = '{3'd2, 2'd0, 5'd11, 32'h80112233, 32'h80112233, 1'b1};
    v[5] = '{3'd0, 2'd1, 5'd12, 32'h80112233, 32'h00000022, 1'b1};
    v[6] = '{3'd1, 2'd0, 5'd13, 32'h0000F00F, 32'hFFFFF00F, 1'b1};
    v[7] = '{3'd4, 2'd0, 5'd31, 32'h000000FF, 32'h000000FF, 1'b1};
    v[8] = '{3'd2, 2'd0, 5'd0,  32'hCAFEF00D, 32'hCAFEF00D, 1'b0};
    for (int i = 0; i < 9; i++) begin
      ld_req_valid = 1; ld_rd = v[i].rd;
      ld_funct3 = v[i].f3; ld_addr_lo = v[i].lo;
      // A response coincident with the request must be dropped.
      mem_rsp_valid = (i == 0); mem_rsp_data = 32'h55555555;
      cyc();
      ld_req_valid = 0; mem_rsp_valid = 0;
      n_tests++;
      if ({ld_busy, ld_busy_rd, ld_req_ready} !== {1'b1, v[i].rd, 1'b0}) begin
        n_fail++;
        $display("FAIL ld%0d_busy: got %b rd=%0d rdy=%b req 1 %0d 0",
                 i, ld_busy, ld_busy_rd, ld_req_ready, v[i].rd);
      end
      cyc();
      mem_rsp_valid = 1; mem_rsp_data = v[i].data;
      cyc();
      mem_rsp_valid = 0; mem_rsp_data = 0;
      n_tests++;
      if ({alu_ready, ld_busy, rf_we} !== 3'b010) begin
        n_fail++;
        $display("FAIL ld%0d_write_state: aluRdy/busy/we=%b%b%b req 010",
                 i, alu_ready, ld_busy, rf_we);
      end
      cyc();
      n_tests++;
      if (rf_we !== v[i].we ||
          (v[i].we && (rf_rd !== v[i].rd || rf_wdata !== v[i].exp))) begin
        n_fail++;
        $display("FAIL ld%0d_data: got we=%b rd=%0d d=%h req %b %0d %h",
                 i, rf_we, rf_rd, rf_wdata, v[i].we, v[i].rd, v[i].exp);
      end
      n_tests++;
      if ({ld_busy, ld_req_ready} !== 2'b01) begin
        n_fail++;
        $display("FAIL ld%0d_idle: busy/rdy=%b%b req 01",
                 i, ld_busy, ld_req_ready);
      end
    end
  endtask

  task automatic test_contention();
    ld_req_valid = 1; ld_rd = 3; ld_funct3 = 3'd2; ld_addr_lo = 0;
    cyc();
    ld_req_valid = 0;
    mem_rsp_valid = 1; mem_rsp_data = 32'h00000055;
    cyc();
    mem_rsp_valid = 0;
    alu_valid = 1; alu_rd = 7; alu_result = 32'h1;
    n_tests++;
    if (alu_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL cont_stall: alu_ready=%b req 0", alu_ready);
    end
    cyc();
    n_tests++;
    if ({rf_we, rf_rd, rf_wdata} !== {1'b1, 5'd3, 32'h55}) begin
      n_fail++;
      $display("FAIL cont_load_first: we=%b rd=%0d d=%h req 1 3 55",
               rf_we, rf_rd, rf_wdata);
    end
    cyc();
    alu_valid = 0;
    n_tests++;
    if ({rf_we, rf_rd, rf_wdata} !== {1'b1, 5'd7, 32'h1}) begin
      n_fail++;
      $display("FAIL cont_alu_after: we=%b rd=%0d d=%h req 1 7 1",
               rf_we, rf_rd, rf_wdata);
    end
    cyc();
  endtask

  task automatic test_errors();
    logic [2:0] ef3[4];
    logic [1:0] elo[4];
    int n;
    ef3[0] = 3'd2; elo[0] = 2'd1;
    ef3[1] = 3'd3; elo[1] = 2'd0;
    ef3[2] = 3'd5; elo[2] = 2'd3;
    ef3[3] = 3'd7; elo[3] = 2'd0;
    for (int i = 0; i < 4; i++) begin
      ld_req_valid = 1; ld_rd = 8; ld_funct3 = ef3[i]; ld_addr_lo = elo[i];
      cyc();
      ld_req_valid = 0;
      n_tests++;
      if ({ld_err, ld_busy, rf_we, ld_req_ready} !== 4'b1001) begin
        n_fail++;
        $display("FAIL err%0d_pulse: err/busy/we/rdy=%b%b%b%b req 1001",
                 i, ld_err, ld_busy, rf_we, ld_req_ready);
      end
      cyc();
      n_tests++;
      if ({ld_err, rf_we} !== 2'b00) begin
        n_fail++;
        $display("FAIL err%0d_clear: err/we=%b%b req 00", i, ld_err, rf_we);
      end
    end
    ld_req_valid = 1; ld_rd = 4; ld_funct3 = 3'd0; ld_addr_lo = 0;
    cyc();
    ld_req_valid = 0;
    n = 0;
    while (ld_busy === 1'b1 && n < 400) begin
      n++;
      cyc();
    end
    n_tests++;
    if (n !== 255) begin
      n_fail++;
      $display("FAIL timeout_cycles: busy for %0d req 255", n);
    end
    n_tests++;
    if ({ld_err, ld_req_ready, rf_we} !== 3'b110) begin
      n_fail++;
      $display("FAIL timeout_err: err/rdy/we=%b%b%b req 110",
               ld_err, ld_req_ready, rf_we);
    end
    cyc();
    n_tests++;
    if ({ld_err, rf_we} !== 2'b00) begin
      n_fail++;
      $display("FAIL timeout_after: err/we=%b%b req 00", ld_err, rf_we);
    end
  endtask

  task automatic test_reset_mid_load();
    ld_req_valid = 1; ld_rd = 6; ld_funct3 = 3'd2; ld_addr_lo = 0;
    cyc();
    ld_req_valid = 0;
    cyc();
    rst = 1;
    cyc();
    rst = 0;
    mem_rsp_valid = 1; mem_rsp_data = 32'h12345678;
    cyc();
    mem_rsp_valid = 0;
    n_tests++;
    if ({rf_we, ld_busy, ld_req_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL rst_wait: we/busy/rdy=%b%b%b req 001",
               rf_we, ld_busy, ld_req_ready);
    end
    cyc();
    n_tests++;
    if (rf_we !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_wait_nowrite: we=%b req 0", rf_we);
    end
    ld_req_valid = 1; ld_rd = 6; ld_funct3 = 3'd2; ld_addr_lo = 0;
    cyc();
    ld_req_valid = 0;
    mem_rsp_valid = 1; mem_rsp_data = 32'h9;
    cyc();
    mem_rsp_valid = 0;
    rst = 1;
    cyc();
    rst = 0;
    n_tests++;
    if ({rf_we, ld_busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_write: we/busy=%b%b req 00", rf_we, ld_busy);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    ld_req_valid = 1; ld_rd = 1; ld_funct3 = 3'd2; ld_addr_lo = 0;
    cyc();
    n_tests++;
    if (ld_busy_rd !== 5'd1) begin
      n_fail++;
      $display("FAIL b2b_brd1: got %0d req 1", ld_busy_rd);
    end
    ld_rd = 2;
    mem_rsp_valid = 1; mem_rsp_data = 32'hA;
    cyc();
    mem_rsp_valid = 0;
    n_tests++;
    if ({ld_req_ready, ld_busy_rd} !== {1'b0, 5'd1}) begin
      n_fail++;
      $display("FAIL b2b_hold: rdy=%b brd=%0d req 0 1",
               ld_req_ready, ld_busy_rd);
    end
    cyc();
    n_tests++;
    if ({rf_we, rf_rd, rf_wdata} !== {1'b1, 5'd1, 32'hA}) begin
      n_fail++;
      $display("FAIL b2b_w1: we=%b rd=%0d d=%h req 1 1 a",
               rf_we, rf_rd, rf_wdata);
    end
    cyc();
    ld_req_valid = 0;
    n_tests++;
    if ({ld_busy, ld_busy_rd} !== {1'b1, 5'd2}) begin
      n_fail++;
      $display("FAIL b2b_brd2: busy=%b brd=%0d req 1 2",
               ld_busy, ld_busy_rd);
    end
    mem_rsp_valid = 1; mem_rsp_data = 32'hB;
    cyc();
    mem_rsp_valid = 0;
    cyc();
    n_tests++;
    if ({rf_we, rf_rd, rf_wdata} !== {1'b1, 5'd2, 32'hB}) begin
      n_fail++;
      $display("FAIL b2b_w2: we=%b rd=%0d d=%h req 1 2 b",
               rf_we, rf_rd, rf_wdata);
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_extract();
    test_contention();
    test_errors();
    test_reset_mid_load();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Writer side of the integer register file write port (rd / data / write-enable).
- Merges single-cycle ALU results with multi-cycle load responses from data memory.
- Extracts and extends load bytes/halfwords, arbitrates the single write port, and raises errors.
- Sits between execute/memory and the register file; also drives the hazard/forwarding signals.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register address width.
- LD_TIMEOUT, 255, max cycles in WAIT_RSP before the load is abandoned (8-bit counter).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU result present
- alu_ready  out  1  ALU result accepted this cycle
- alu_rd  in  RA_W  ALU destination
- alu_result  in  XLEN  ALU value
- ld_req_valid  in  1  load issued
- ld_req_ready  out  1  load tracker free
- ld_rd  in  RA_W  load destination
- ld_funct3  in  3  0=LB 1=LH 2=LW 4=LBU 5=LHU
- ld_addr_lo  in  2  byte offset of load address
- mem_rsp_valid  in  1  memory word returned (one-cycle pulse)
- mem_rsp_data  in  XLEN  aligned 32-bit word
- rf_we  out  1  register file write enable (registered)
- rf_rd  out  RA_W  register file write address (registered)
- rf_wdata  out  XLEN  register file write data (registered)
- ld_busy  out  1  load outstanding
- ld_busy_rd  out  RA_W  destination of outstanding load, for the hazard unit
- ld_err  out  1  one-cycle pulse: misaligned, illegal funct3 or timeout

Behaviour:
- Reset: all outputs 0 except ld_req_ready=1 and alu_ready=1; FSM=IDLE; timeout counter 0; any pending load is dropped; no write.
- FSM IDLE:
  - ld_req_ready=1.
  - ld_req_valid=1 with legal funct3 and aligned address: capture rd/funct3/addr_lo, go to WAIT_RSP.
  - Illegal funct3 (3,6,7), or misaligned (LH/LHU with addr_lo[0]=1; LW with addr_lo!=0): ld_err pulses next cycle, stay in IDLE, no write.
- FSM WAIT_RSP:
  - ld_req_ready=0, ld_busy=1, ld_busy_rd=captured rd, counter increments each cycle.
  - mem_rsp_valid: extract and extend the data into a holding register, go to WRITE.
  - Counter reaches LD_TIMEOUT with no response: ld_err pulse, go to IDLE, no write.
- FSM WRITE:
  - Write port belongs to the load; alu_ready=0.
  - Next cycle: rf_we=1, rf_rd=captured rd, rf_wdata=load value.
  - Go to IDLE; ld_busy stays 1 through WRITE.
- Extraction (byte select = addr_lo):
  - LB / LBU: byte = data[8*addr_lo +: 8], sign- or zero-extended to 32 bits.
  - LH / LHU: half = data[16*addr_lo[1] +: 16], sign- or zero-extended.
  - LW: whole word.
- ALU path:
  - alu_ready=1 in every state except WRITE.
  - alu_valid & alu_ready: next cycle rf_we=1, rf_rd=alu_rd, rf_wdata=alu_result (latency 1).
  - If the ALU handshake does not occur, rf_we=0 the next cycle.
- x0: any write with rd=0 yields rf_we=0 (rf_rd/rf_wdata don't-care). The FSM still sequences normally for loads to x0.
- Simultaneous ld_req and mem_rsp in IDLE: the response is ignored (no load outstanding), the request is accepted.
- A mem_rsp_valid in IDLE or WRITE is ignored.
- ld_req_valid outside IDLE is not accepted; the requester holds it until ld_req_ready.
- rst asserted mid-WAIT_RSP or mid-WRITE: no write occurs on the following cycle; a response arriving after reset is ignored.
- rf_we never asserts on two sources in the same cycle; the load always wins the WRITE-state slot.

Test Plan:
- ALU write: alu_valid, rd=5, result=0xDEADBEEF -> next cycle rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF; rd=0 variant -> rf_we=0.
- LB, addr_lo=3, rsp data=0x80112233 -> 3 cycles after response... specifically: WRITE entered the cycle after the response, rf_wdata=0xFFFFFF80 one cycle later; LBU same stimulus -> 0x00000080; LH, addr_lo=2 -> 0xFFFF8011; LW -> 0x80112233.
- Contention: response arrives while alu_valid is held with rd=7, value 0x1 -> alu_ready=0 during WRITE, load write first, then rf_rd=7, rf_wdata=1 the cycle after.
- Errors: LW with addr_lo=1 -> ld_err pulse, ld_busy stays 0, no write; funct3=3 -> ld_err; no response for 255 cycles -> ld_err, back to IDLE, ld_req_ready=1.
- Reset while in WAIT_RSP, then mem_rsp_valid with data=0x12345678 -> rf_we stays 0, ld_busy=0, ld_req_ready=1.
- Back-to-back loads to rd=1 and rd=2 with responses 0xA and 0xB -> two writes in order; ld_busy_rd tracks 1 then 2.
